// File: rtl/shift_sequencer.sv
// Multi-pass shift sequencer: splits a wide shift amount into passes of at most 7
// through an external 8-bit barrel shifter. Optional op counter: SHIFT_SEQUENCER_STATS_EN.
module shift_sequencer #(
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [7:0]       req_din,
   input  logic [AMT_W-1:0] req_amt,
   input  logic             req_lr,
   input  logic             req_al,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_dout,
   output logic [7:0]       bs_din,
   output logic [2:0]       bs_shamt,
   output logic             bs_lr,
   output logic             bs_al,
   input  logic [7:0]       bs_dout,
`ifdef SHIFT_SEQUENCER_STATS_EN
   output logic [15:0]      op_count,
`endif
   output logic             busy
);

   // Remaining-amount register is at least 3 bits so the per-pass clamp is well formed.
   localparam int RW = (AMT_W < 3) ? 3 : AMT_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    acc_q, acc_d;
   logic [RW-1:0] rem_q, rem_d;
   logic          lr_q, lr_d;
   logic          al_q, al_d;
   logic          req_ready_q;
   logic          busy_q;
   logic          res_valid_q;
   logic [2:0]    pass_amt;
   logic          in_shift;

   assign pass_amt = (rem_q > RW'(7)) ? 3'd7 : rem_q[2:0];
   assign in_shift = (state_q == SHIFT);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      lr_d    = lr_q;
      al_d    = al_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               acc_d   = req_din;
               rem_d   = RW'(req_amt);
               lr_d    = req_lr;
               al_d    = req_al;
               state_d = (req_amt != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            acc_d = bs_dout;
            rem_d = rem_q - RW'(pass_amt);
            if (rem_d == '0) state_d = DONE;
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         rem_q       <= '0;
         lr_q        <= 1'b0;
         al_q        <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         rem_q       <= rem_d;
         lr_q        <= lr_d;
         al_q        <= al_d;
         req_ready_q <= (state_d == IDLE);
         busy_q      <= (state_d != IDLE);
         res_valid_q <= (state_d == DONE);
      end
   end

   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign res_valid = res_valid_q;
   assign res_dout  = res_valid_q ? acc_q : 8'h00;

   assign bs_din   = in_shift ? acc_q : 8'h00;
   assign bs_shamt = in_shift ? pass_amt : 3'd0;
   assign bs_lr    = in_shift & lr_q;
   assign bs_al    = in_shift & al_q;

`ifdef SHIFT_SEQUENCER_STATS_EN
   logic [15:0] op_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_count_q <= 16'h0000;
      end else if ((state_q == DONE) && res_ready) begin
         op_count_q <= op_count_q + 16'h0001;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural 8-bit barrel shifter
// attached to the bs_* port group.
module tb_shift_sequencer;

   localparam int AMT_W = 5;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [7:0]       req_din;
   logic [AMT_W-1:0] req_amt;
   logic             req_lr;
   logic             req_al;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       res_dout;
   logic [7:0]       bs_din;
   logic [2:0]       bs_shamt;
   logic             bs_lr;
   logic             bs_al;
   logic [7:0]       bs_dout;
   logic             busy;
`ifdef SHIFT_SEQUENCER_STATS_EN
   logic [15:0]      op_count;
   int               exp_ops;
`endif

   int n_cmp;
   int n_err;
   logic [7:0] exp_q[$];

   shift_sequencer #(.AMT_W(AMT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_din   (req_din),
      .req_amt   (req_amt),
      .req_lr    (req_lr),
      .req_al    (req_al),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_dout  (res_dout),
      .bs_din    (bs_din),
      .bs_shamt  (bs_shamt),
      .bs_lr     (bs_lr),
      .bs_al     (bs_al),
      .bs_dout   (bs_dout),
`ifdef SHIFT_SEQUENCER_STATS_EN
      .op_count  (op_count),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream barrel shifter, combinational.
   always_comb begin
      bs_dout = 8'h00;
      if (bs_lr)      bs_dout = bs_din << bs_shamt;
      else if (bs_al) bs_dout = 8'($signed(bs_din) >>> bs_shamt);
      else            bs_dout = bs_din >> bs_shamt;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Bit-at-a-time reference, independent of the pass split.
   function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt,
                                            input logic lr, input logic al);
      logic [7:0] r;
      r = d;
      for (int i = 0; i < amt; i++)
         r = lr ? {r[6:0], 1'b0} : {al & r[7], r[7:1]};
      return r;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_req(input logic [7:0] din, input int amt, input logic lr,
                          input logic al, input logic [7:0] exp, input int hold);
      int npass;
      int rem;
      logic [7:0] held;
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_din   = din;
      req_amt   = AMT_W'(amt);
      req_lr    = lr;
      req_al    = al;
      exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      npass = 0;
      rem   = amt;
      while (!res_valid && npass < 20) begin
         check("bs_shamt", bs_shamt, (rem > 7) ? 7 : rem);
         check("bs_lr", bs_lr, lr);
         check("busy_shift", busy, 1);
         check("ready_shift", req_ready, 0);
         rem = rem - ((rem > 7) ? 7 : rem);
         npass++;
         @(negedge clk);
      end
      check("res_valid_rise", res_valid, 1);
      check("pass_count", npass, (amt + 6) / 7);
      check("bs_shamt_done", bs_shamt, 0);
      check("bs_din_done", bs_din, 0);
      check("res_dout", res_dout, exp_q.pop_front());
      held = res_dout;
      res_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         req_valid = i[0] ? 1'b0 : 1'b1;
         req_din   = 8'h3C;
         req_amt   = AMT_W'(1);
         @(negedge clk);
         check("hold_dout", res_dout, held);
         check("hold_valid", res_valid, 1);
         check("hold_ready", req_ready, 0);
      end
      // Offer a request on the handshake edge itself; it must not be taken.
      req_valid = 1'b1;
      req_din   = 8'h77;
      req_amt   = AMT_W'(2);
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      res_ready = 1'b0;
      check("valid_drop", res_valid, 0);
      check("idle_ready", req_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_dout", res_dout, 0);
`ifdef SHIFT_SEQUENCER_STATS_EN
      exp_ops++;
      check("op_count", op_count, 32'(exp_ops));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      int a;
      logic l;
      logic k;
      n_cmp = 0;
      n_err = 0;
`ifdef SHIFT_SEQUENCER_STATS_EN
      exp_ops = 0;
`endif
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_din = 8'h00;
      req_amt = '0;
      req_lr = 1'b0;
      req_al = 1'b0;
      res_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_ready", req_ready, 1);
      check("rst_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_dout", res_dout, 0);
      check("rst_bs_din", bs_din, 0);
`ifdef SHIFT_SEQUENCER_STATS_EN
      check("rst_op_count", op_count, 0);
`endif

      run_req(8'hB4, 3,  1'b1, 1'b0, 8'hA0, 0);
      run_req(8'h90, 10, 1'b0, 1'b1, 8'hFF, 0);
      run_req(8'hF0, 4,  1'b0, 1'b0, 8'h0F, 0);
      run_req(8'h81, 9,  1'b1, 1'b0, 8'h00, 0);
      run_req(8'h5A, 0,  1'b0, 1'b0, 8'h5A, 0);
      run_req(8'h6B, 0,  1'b1, 1'b1, 8'h6B, 3);
      run_req(8'h7F, 31, 1'b0, 1'b1, 8'h00, 0);
      run_req(8'h80, 31, 1'b0, 1'b1, 8'hFF, 0);
      run_req(8'hFF, 8,  1'b0, 1'b0, 8'h00, 0);
      run_req(8'hC3, 7,  1'b1, 1'b1, 8'h80, 0);
      run_req(8'hC3, 14, 1'b0, 1'b1, 8'hFF, 2);

      for (int n = 0; n < 20; n++) begin
         d = 8'($urandom);
         a = int'($urandom_range(0, 31));
         l = 1'($urandom);
         k = 1'($urandom);
         run_req(d, a, l, k, ref_shift(d, a, l, k), int'($urandom_range(0, 2)));
      end

      // Abort mid-shift with a synchronous reset.
      req_valid = 1'b1;
      req_din   = 8'hA5;
      req_amt   = AMT_W'(20);
      req_lr    = 1'b1;
      req_al    = 1'b0;
      exp_q.push_back(ref_shift(8'hA5, 20, 1'b1, 1'b0));
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_in_shift", busy, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
`ifdef SHIFT_SEQUENCER_STATS_EN
      exp_ops = 0;
      check("abort_op_count", op_count, 0);
`endif
      check("abort_ready", req_ready, 1);
      check("abort_valid", res_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_shamt", bs_shamt, 0);
      res_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("abort_no_result", res_valid, 0);
      end
      res_ready = 1'b0;
      run_req(8'h01, 5, 1'b1, 1'b0, 8'h20, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
